// File: rtl/display_mux_7seg_if.sv
// Signal bundle between the BCD source / board pins and the 7-segment scan mux.
// The master side supplies the value to show; the slave side (the mux) drives the pins.
interface display_mux_7seg_if;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_start;

    modport master (
        output load, bcd_in, dp_in, lz_en,
        input  an, seg, dp, digit_idx, frame_start
    );

    modport slave (
        input  load, bcd_in, dp_in, lz_en,
        output an, seg, dp, digit_idx, frame_start
    );
endinterface

// File: rtl/display_mux_7seg.sv
// 4-digit multiplexed 7-segment driver. Scans digits with a per-slot dwell,
// blanks the anodes at the head of each slot to avoid ghosting, optionally
// suppresses leading zeros, and only swaps in a new BCD value at a frame boundary.
module display_mux_7seg #(
    parameter int DWELL      = 4,
    parameter int BLANK      = 1,
    parameter int ACTIVE_LOW = 1
) (
    input logic               clk1kHz,
    input logic               reset,
    display_mux_7seg_if.slave bus
);

    localparam int             CNT_W   = $clog2(DWELL);
    localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL - 1);
    localparam bit             INV     = (ACTIVE_LOW != 0);
    localparam logic [3:0]     AN_OFF  = INV ? 4'hF : 4'h0;
    localparam logic [6:0]     SEG_OFF = INV ? 7'h7F : 7'h00;
    localparam logic           DP_OFF  = INV;

    // Active-high {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      bcd_q, bcd_d, pbcd_q, pbcd_d;
    logic [3:0]       dpm_q, dpm_d, pdp_q, pdp_d;
    logic             pend_q, pend_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             fs_q, fs_d;

    logic             boundary;
    logic             dark;
    logic             lit;
    logic [3:0]       nib;
    logic [3:0]       an_act;
    logic [6:0]       seg_act;
    logic             dp_act;

    // Next scan position, frame-boundary value swap, and the outputs for the
    // state being entered so that index, anodes and segments move together.
    always_comb begin
        dwell_d  = dwell_q;
        idx_d    = idx_q;
        bcd_d    = bcd_q;
        dpm_d    = dpm_q;
        pbcd_d   = pbcd_q;
        pdp_d    = pdp_q;
        pend_d   = pend_q;
        boundary = (dwell_q == DW_LAST) && (idx_q == 2'd3);

        if (dwell_q == DW_LAST) begin
            dwell_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            dwell_d = dwell_q + CNT_W'(1);
        end

        // A load on the boundary edge wins over anything pending.
        if (boundary) begin
            if (bus.load) begin
                bcd_d = bus.bcd_in;
                dpm_d = bus.dp_in;
            end else if (pend_q) begin
                bcd_d = pbcd_q;
                dpm_d = pdp_q;
            end
            pend_d = 1'b0;
        end else if (bus.load) begin
            pbcd_d = bus.bcd_in;
            pdp_d  = bus.dp_in;
            pend_d = 1'b1;
        end

        nib = bcd_d[idx_d*4 +: 4];
        case (idx_d)
            2'd3:    dark = bus.lz_en && (bcd_d[15:12] == 4'd0);
            2'd2:    dark = bus.lz_en && (bcd_d[15:8] == 8'd0);
            2'd1:    dark = bus.lz_en && (bcd_d[15:4] == 12'd0);
            default: dark = 1'b0;
        endcase

        lit     = (int'(dwell_d) >= BLANK) && !dark;
        an_act  = lit ? (4'b0001 << idx_d) : 4'b0000;
        seg_act = lit ? decode(nib) : 7'b0000000;
        dp_act  = lit && dpm_d[idx_d];

        an_d  = INV ? ~an_act : an_act;
        seg_d = INV ? ~seg_act : seg_act;
        dp_d  = INV ? ~dp_act : dp_act;
        fs_d  = (idx_d == 2'd0) && (dwell_d == '0);
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge clk1kHz or posedge reset) begin
        if (reset) begin
            dwell_q <= '0;
            idx_q   <= 2'd0;
            bcd_q   <= '0;
            dpm_q   <= '0;
            pbcd_q  <= '0;
            pdp_q   <= '0;
            pend_q  <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            fs_q    <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            dpm_q   <= dpm_d;
            pbcd_q  <= pbcd_d;
            pdp_q   <= pdp_d;
            pend_q  <= pend_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.digit_idx   = idx_q;
    assign bus.frame_start = fs_q;

endmodule
